// File: rtl/bar_cmd_tx_pkg.sv
// Shared types and constants for the bar command transmitter.
// Holds the FSM state encoding, command word layout and a command builder.
package bar_cmd_pkg;

  localparam int SEL_BIT       = 10;
  localparam int Y_W           = 10;
  localparam int CMD_W         = 32;
  localparam int Y_MAX_DEFAULT = 500;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SEND1  = 2'd2,
    ST_SEND2  = 2'd3
  } state_e;

  // Command word: bar select in bit SEL_BIT, Y in the low bits, rest zero.
  function automatic logic [CMD_W-1:0] make_cmd(input logic sel, input logic [Y_W-1:0] y);
    logic [CMD_W-1:0] c;
    c            = '0;
    c[SEL_BIT]   = sel;
    c[Y_W-1:0]   = y;
    return c;
  endfunction

endpackage

// File: rtl/bar_cmd_tx_if.sv
// Command channel between the transmitter and the display's custom instruction.
// Handshake: the sink raises I_READY when it can take a word; a transfer happens
// on a cycle where O_CLK_EN is high, and O_DATAA is only meaningful then.
interface bar_cmd_tx_if;
  import bar_cmd_pkg::*;

  logic             I_READY;
  logic [CMD_W-1:0] O_DATAA;
  logic             O_CLK_EN;

  modport master (input I_READY, output O_DATAA, output O_CLK_EN);
  modport slave  (output I_READY, input O_DATAA, input O_CLK_EN);

endinterface

// File: rtl/bar_cmd_tx_in_sync.sv
// Two-flop synchronizer for the four buttons and VS, plus a VS falling-edge tick.
// Reset loads the inactive (high) level so no spurious tick follows reset.
module in_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] btn_n_i,
  input  logic       vs_i,
  output logic [3:0] btn_n_o,
  output logic       tick_o
);

  logic [4:0] s1_q;
  logic [4:0] s2_q;
  logic       vs_prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= '1;
      s2_q      <= '1;
      vs_prev_q <= 1'b1;
    end else begin
      s1_q      <= {vs_i, btn_n_i};
      s2_q      <= s1_q;
      vs_prev_q <= s2_q[4];
    end
  end

  assign btn_n_o = s2_q[3:0];
  assign tick_o  = vs_prev_q & ~s2_q[4];

endmodule

// File: rtl/bar_cmd_tx.sv
// Per-frame bar position update and command transmitter for the two-bar display.
// Positions saturate in [Y_MIN, Y_MAX]; only changed bars are sent unless forced.
module bar_cmd_tx
  import bar_cmd_pkg::*;
#(
  parameter int Y_INIT = 250,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = Y_MAX_DEFAULT,
  parameter int STEP   = 4
) (
  input  logic                CLK,
  input  logic                RST_BTN,
  input  logic [3:0]          BTN_N,
  input  logic                VGA_VS_I,
  bar_cmd_tx_if.master        cmd,
  output state_e              dbg_state_o
);

  localparam logic [Y_W:0]   STEP_X = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]   YMIN_X = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0]   YMAX_X = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0] YINIT  = Y_W'(Y_INIT);

  logic [3:0] btn_n_s;
  logic       tick;

  in_sync u_in_sync (
    .clk_i   (CLK),
    .rst_ni  (RST_BTN),
    .btn_n_i (BTN_N),
    .vs_i    (VGA_VS_I),
    .btn_n_o (btn_n_s),
    .tick_o  (tick)
  );

  state_e           state_q, state_d;
  logic [Y_W-1:0]   y1_q, y1_d, y2_q, y2_d;
  logic [Y_W-1:0]   last1_q, last1_d, last2_q, last2_d;
  logic             force_q, force_d;
  logic             pending_q, pending_d;
  logic [CMD_W-1:0] dataa_q, dataa_d;
  logic             clk_en_q, clk_en_d;
  logic             need1, need2;

  // One extra bit of headroom so y-STEP and y+STEP are compared before truncation.
  function automatic logic [Y_W-1:0] move(input logic [Y_W-1:0] y,
                                          input logic up_n, input logic dn_n);
    logic [Y_W:0] y_x;
    logic [Y_W:0] r;
    y_x = {1'b0, y};
    r   = y_x;
    if (!up_n && dn_n) begin
      r = (y_x < YMIN_X + STEP_X) ? YMIN_X : y_x - STEP_X;
    end else if (up_n && !dn_n) begin
      r = (y_x + STEP_X > YMAX_X) ? YMAX_X : y_x + STEP_X;
    end
    return r[Y_W-1:0];
  endfunction

  assign need1 = (y1_q != last1_q) | force_q;
  assign need2 = (y2_q != last2_q) | force_q;

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      state_q   <= ST_IDLE;
      y1_q      <= YINIT;
      y2_q      <= YINIT;
      last1_q   <= '0;
      last2_q   <= '0;
      force_q   <= 1'b1;
      pending_q <= 1'b0;
      dataa_q   <= '0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      last1_q   <= last1_d;
      last2_q   <= last2_d;
      force_q   <= force_d;
      pending_q <= pending_d;
      dataa_q   <= dataa_d;
      clk_en_q  <= clk_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    last1_d   = last1_q;
    last2_d   = last2_q;
    force_d   = force_q;
    pending_d = pending_q;
    dataa_d   = dataa_q;
    clk_en_d  = 1'b0;

    // At most one frame is queued while busy; later ticks collapse into it.
    if (tick && state_q != ST_IDLE) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_UPDATE;
          pending_d = 1'b0;
        end
      end
      ST_UPDATE: begin
        y1_d    = move(y1_q, btn_n_s[0], btn_n_s[1]);
        y2_d    = move(y2_q, btn_n_s[2], btn_n_s[3]);
        state_d = ST_SEND1;
      end
      ST_SEND1: begin
        if (!need1) begin
          state_d = ST_SEND2;
        end else if (cmd.I_READY) begin
          clk_en_d = 1'b1;
          dataa_d  = make_cmd(1'b0, y1_q);
          last1_d  = y1_q;
          state_d  = ST_SEND2;
        end
      end
      ST_SEND2: begin
        if (!need2) begin
          state_d = ST_IDLE;
          force_d = 1'b0;
        end else if (cmd.I_READY) begin
          clk_en_d = 1'b1;
          dataa_d  = make_cmd(1'b1, y2_q);
          last2_d  = y2_q;
          state_d  = ST_IDLE;
          force_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd.O_DATAA  = dataa_q;
  assign cmd.O_CLK_EN = clk_en_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bar_cmd_tx.sv
// Directed self-checking bench for bar_cmd_tx: first frame, motion, saturation,
// ready stall with queued ticks, and reset in the middle of a transfer.
module tb_bar_cmd_tx;
  import bar_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_btn;
  logic [3:0] btn_n;
  logic       vs;
  state_e     dbg_state;

  always #5 clk = ~clk;

  bar_cmd_tx_if cmd_if ();

  bar_cmd_tx dut (
    .CLK         (clk),
    .RST_BTN     (rst_btn),
    .BTN_N       (btn_n),
    .VGA_VS_I    (vs),
    .cmd         (cmd_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input state_e target, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (dbg_state == target) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Pulse VS for two cycles and collect every strobe seen in the following window.
  task automatic run_frame(input string tag, input int n_exp,
                           input logic [31:0] e0, input logic [31:0] e1);
    logic [31:0] got_q[$];
    int          cyc_q[$];
    logic [31:0] g;
    if (n_exp > 0) exp_q.push_back(e0);
    if (n_exp > 1) exp_q.push_back(e1);
    vs = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (cmd_if.O_CLK_EN) begin
        got_q.push_back(cmd_if.O_DATAA);
        cyc_q.push_back(c);
      end
      if (c == 1) vs = 1'b1;
    end
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      check($sformatf("%s_word%0d", tag, i), g, exp_q.pop_front());
    end
    if (n_exp == 2 && got_q.size() == 2)
      check($sformatf("%s_back2back", tag), 32'(cyc_q[1] - cyc_q[0]), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] got_q[$];
    int          updates;
    logic [31:0] g;
    logic [9:0]  y2;

    rst_btn        = 1'b0;
    btn_n          = 4'hF;
    vs             = 1'b1;
    cmd_if.I_READY = 1'b1;
    idle_cycles(3);
    check("rst_clk_en", 32'(cmd_if.O_CLK_EN), 32'd0);
    check("rst_dataa", cmd_if.O_DATAA, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_btn = 1'b1;
    idle_cycles(3);

    // First frame after reset sends both bars at Y_INIT.
    run_frame("first", 2, 32'h0FA, 32'h4FA);
    check("first_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Bar1 down for three frames.
    btn_n = 4'b1101;
    idle_cycles(3);
    run_frame("b1dn0", 1, 32'h0FE, 32'h0);
    run_frame("b1dn1", 1, 32'h102, 32'h0);
    run_frame("b1dn2", 1, 32'h106, 32'h0);

    // Bar2 up from 250 down to 2, then saturate at 0, then silence.
    btn_n = 4'b1011;
    idle_cycles(3);
    y2 = 10'd250;
    for (int i = 0; i < 62; i++) begin
      y2 = y2 - 10'd4;
      run_frame($sformatf("b2up%0d", i), 1, {22'h1, y2}, 32'h0);
    end
    run_frame("b2sat", 1, 32'h400, 32'h0);
    run_frame("b2quiet", 0, 32'h0, 32'h0);

    // Stall in SEND1 with two VS ticks arriving meanwhile.
    btn_n          = 4'b1110;
    cmd_if.I_READY = 1'b0;
    idle_cycles(3);
    vs = 1'b0;
    idle_cycles(2);
    vs = 1'b1;
    wait_state("stall_reach_send1", ST_SEND1, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_clk_en%0d", i), 32'(cmd_if.O_CLK_EN), 32'd0);
      check($sformatf("stall_dataa%0d", i), cmd_if.O_DATAA, 32'h400);
      if (i == 2 || i == 6) vs = 1'b0;
      if (i == 4 || i == 8) vs = 1'b1;
    end
    check("stall_still_send1", 32'(dbg_state), 32'(ST_SEND1));
    cmd_if.I_READY = 1'b1;
    @(negedge clk);
    check("ready_rise_strobe", 32'(cmd_if.O_CLK_EN), 32'd1);
    check("ready_rise_dataa", cmd_if.O_DATAA, 32'h102);
    exp_q.push_back(32'h0FE);
    updates = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (cmd_if.O_CLK_EN) got_q.push_back(cmd_if.O_DATAA);
      if (dbg_state == ST_UPDATE) updates++;
    end
    check("queued_updates", 32'(updates), 32'd1);
    check("queued_count", 32'(got_q.size()), 32'd1);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    check("queued_word", g, exp_q.pop_front());
    check("queued_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Reset while SEND2 is stalled.
    btn_n          = 4'b0111;
    cmd_if.I_READY = 1'b0;
    idle_cycles(3);
    vs = 1'b0;
    idle_cycles(2);
    vs = 1'b1;
    wait_state("rst_reach_send2", ST_SEND2, 12);
    check("send2_stall_dataa", cmd_if.O_DATAA, 32'h0FE);
    check("send2_stall_clk_en", 32'(cmd_if.O_CLK_EN), 32'd0);
    rst_btn = 1'b0;
    @(negedge clk);
    check("midrst_clk_en", 32'(cmd_if.O_CLK_EN), 32'd0);
    check("midrst_dataa", cmd_if.O_DATAA, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    btn_n = 4'hF;
    @(negedge clk);
    rst_btn        = 1'b1;
    cmd_if.I_READY = 1'b1;
    idle_cycles(3);
    run_frame("post_rst", 2, 32'h0FA, 32'h4FA);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bar_cmd_tx.md
# bar_cmd_tx

Command transmitter for the two-bar VGA display. Synchronizes four player buttons and tracks the vertical-sync signal. Once per frame it updates two saturating bar Y positions and emits the display's custom-instruction write: a 32-bit command word plus a single-cycle enable strobe. It drives the display block's `dataa` and `CLK_EN` inputs directly, replacing software-issued writes.

## Interface
Parameters:
- `Y_INIT`, 250: Y position of both bars after reset.
- `Y_MIN`, 0: lowest allowed Y.
- `Y_MAX`, 500: highest allowed Y (600 − bar height 100).
- `STEP`, 4: pixels moved per frame while a button is held.

Ports:
- `CLK`  in  1  board clock; all logic on its rising edge.
- `RST_BTN`  in  1  reset; synchronous, active-low.
- `BTN_N`  in  4  raw buttons, active-low, asynchronous:
  - [0] bar1 up, [1] bar1 down
  - [2] bar2 up, [3] bar2 down
- `VGA_VS_I`  in  1  vertical sync from the VGA timing block; active-low pulse.
- `I_READY`  in  1  sink can accept a command this cycle.
- `O_DATAA`  out  32  command word:
  - [31:11] = 0
  - [10] = bar select (0 = bar1, 1 = bar2)
  - [9:0] = Y
- `O_CLK_EN`  out  1  one-cycle command strobe; `O_DATAA` is valid while it is high.

## Operation
- Buttons and `VGA_VS_I` pass through a 2-FF synchronizer. Frame tick = synchronized VS 1→0 edge, one cycle wide.
- FSM states:
  - IDLE: on tick or pending → UPDATE, and clear pending.
  - UPDATE: apply motion, then → SEND1.
  - SEND1: wait for `I_READY`; if bar1 needs sending, strobe with sel = 0; then → SEND2.
  - SEND2: same for bar2 with sel = 1; then → IDLE.
  - If a bar does not need sending, its SEND state lasts one cycle without a strobe, regardless of `I_READY`.
- Motion per bar, evaluated in UPDATE from the synchronized buttons:
  - Up only: y = max(y − STEP, Y_MIN).
  - Down only: y = min(y + STEP, Y_MAX).
  - Both or neither: no change.
  - Arithmetic uses 11 bits so underflow and overflow cannot wrap before saturation.
- "Needs sending": y differs from the last transmitted value of that bar, or the `force` flag is set.
  - `force` is set by reset and cleared at exit from SEND2.
  - Result: both bars are always sent on the first frame after reset.
- Strobe rule: `O_CLK_EN` = 1 only in a SEND state with `I_READY` = 1 and needs-sending true. The FSM advances on that cycle and records the last transmitted value.
- `I_READY` low: the FSM holds the SEND state and `O_DATAA` stays stable. There is no timeout.
- Tick arriving outside IDLE sets `pending`. Further ticks while pending is set are dropped, so at most one frame is queued.
- Reset mid-transfer: the FSM returns to IDLE next edge and any partially sent frame is abandoned. The following tick resends both bars because `force` is set again.

## Timing
- Reset values:
  - `O_CLK_EN` = 0, `O_DATAA` = 0.
  - Both Y = `Y_INIT`; last-sent values = 0.
  - force = 1, pending = 0, FSM = IDLE.
- VS falling edge at pin, cycle N: synchronized tick in N+2, UPDATE in N+3, SEND1 in N+4.
- With `I_READY` held high: bar1 strobe in N+4, bar2 strobe in N+5, IDLE in N+6.
- `O_DATAA` and `O_CLK_EN` are registered outputs. The strobe is never high on two consecutive cycles for the same bar.
- `O_DATAA` keeps its last value when no strobe is active.

## Structure
- Shared package `bar_cmd_pkg`:
  - FSM state enum (IDLE, UPDATE, SEND1, SEND2).
  - `SEL_BIT` = 10, `Y_W` = 10, `CMD_W` = 32.
  - Default `Y_MAX`.
- Sub-module `in_sync`: 2-FF synchronizer for the 5 inputs plus VS falling-edge detector, outputting the tick.
- Top-level `bar_cmd_tx` holds the position datapath, the FSM and the output registers.

## Test plan
- Reset, then one VS pulse with `I_READY` = 1 and no buttons → two strobes on consecutive cycles, `O_DATAA` = 0x0FA then 0x4FA.
- `BTN_N[1]` low over 3 frames → bar1 strobes with Y = 254, 258, 262 (0x0FE, 0x102, 0x106); no bar2 strobes.
- Bar2 held up from Y = 2, `STEP` = 4 → next command is 0x400 (saturates at 0), then no further bar2 strobes.
- `I_READY` low for 10 cycles in SEND1 → no strobe and `O_DATAA` stable; strobe occurs the cycle `I_READY` rises.
- Two VS ticks during a stalled SEND → exactly one extra UPDATE after return to IDLE; second tick dropped.
- `RST_BTN` low during SEND2 → next cycle `O_CLK_EN` = 0 and `O_DATAA` = 0; next frame sends 0x0FA and 0x4FA.
